seg_scan_decoder: RTL

//  Reads back the multiplexed 7-segment bus (seg0..seg6, dp, an0..an3) produced by the display controller.
//  It decodes each scanned digit pattern back to a hex nibble and reassembles the 16-bit value shown on the display.
//  It gives a loop-back / self-check path for the sensor display chain, so it can be compared against the counter's value.

---
 rtl/seg_scan_decoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back a scanned 7-segment bus and reassembles the 16-bit displayed value.
// Optional SEG_INPUT_SYNC_EN adds a 2-flop input synchroniser, which allows an asynchronous bus and adds 2 cycles of latency.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 8,
  parameter int FRAME_TIMEOUT = 1000000,
  parameter int TO_W          = 20
) (
  input  logic        fpga_clk1,
  input  logic        reset,
  input  logic        seg0,
  input  logic        seg1,
  input  logic        seg2,
  input  logic        seg3,
  input  logic        seg4,
  input  logic        seg5,
  input  logic        seg6,
  input  logic        dp,
  input  logic        an0,
  input  logic        an1,
  input  logic        an2,
  input  logic        an3,
  output logic [15:0] value_out,
  output logic        value_valid,
  output logic        digit_err,
  output logic        stale
);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  logic [11:0]    raw, smp;
  logic [11:0]    prev_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cap_q, cap_d;
  logic           same, one_hot, capture, complete;
  logic [3:0]     an_act;
  logic [1:0]     idx;
  logic [4:0]     dec;
  logic [3:0]     seen_q, seen_d, err_q, err_d;
  logic [15:0]    shadow_q, shadow_d;
  logic [15:0]    value_q;
  logic           valid_q, derr_q, stale_q;
  logic [TO_W-1:0] to_q, to_d;
  assign raw = {an3, an2, an1, an0, seg6, seg5, seg4, seg3, seg2, seg1, seg0, dp};
`ifdef SEG_INPUT_SYNC_EN
  logic [11:0] sync1_q, sync2_q;
  // Two-flop synchroniser; resets to the idle (all-high) bus.
  always_ff @(posedge fpga_clk1 or negedge reset)
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  assign smp = sync2_q;
`else
  assign smp = raw;
`endif
  // Returns {err, nibble}; anything that is not one of the 16 hex glyphs decodes to 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7D:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h6F:   decode = 5'h09;
      7'h77:   decode = 5'h0A;
      7'h7C:   decode = 5'h0B;
      7'h39:   decode = 5'h0C;
      7'h5E:   decode = 5'h0D;
      7'h79:   decode = 5'h0E;
      7'h71:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction
  assign same     = smp == prev_q;
  assign cnt_d    = !same ? '0 : (cnt_q == CW'(SETTLE_CYCLES - 1) ? cnt_q : cnt_q + 1'b1);
  assign an_act   = ~smp[11:8];
  assign one_hot  = an_act != 4'd0 && (an_act & (an_act - 4'd1)) == 4'd0;
  assign capture  = same && !cap_q && one_hot && cnt_d == CW'(SETTLE_CYCLES - 1);
  assign cap_d    = same && (cap_q || capture);
  assign idx      = an_act[3] ? 2'd3 : an_act[2] ? 2'd2 : an_act[1] ? 2'd1 : 2'd0;
  assign dec      = decode(~smp[7:1]);
  assign complete = seen_q == 4'hF;
  assign to_d     = complete ? '0 : (to_q == TO_W'(FRAME_TIMEOUT) ? to_q : to_q + 1'b1);
  // Frame bookkeeping: completion clears the masks first so a same-cycle capture opens the next frame.
  always_comb begin
    seen_d   = complete ? 4'h0 : seen_q;
    err_d    = complete ? 4'h0 : err_q;
    shadow_d = shadow_q;
    if (capture) begin
      seen_d[idx]               = 1'b1;
      err_d[idx]                = dec[4];
      shadow_d[{idx, 2'b00} +: 4] = dec[3:0];
    end
  end
  // State and registered outputs.
  always_ff @(posedge fpga_clk1 or negedge reset)
    if (!reset) begin
      prev_q   <= '1;
      cnt_q    <= '0;
      cap_q    <= 1'b0;
      seen_q   <= 4'h0;
      err_q    <= 4'h0;
      shadow_q <= 16'h0;
      value_q  <= 16'h0;
      valid_q  <= 1'b0;
      derr_q   <= 1'b0;
      to_q     <= '0;
      stale_q  <= 1'b0;
    end else begin
      prev_q   <= smp;
      cnt_q    <= cnt_d;
      cap_q    <= cap_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      valid_q  <= complete;
      to_q     <= to_d;
      stale_q  <= !complete && to_d == TO_W'(FRAME_TIMEOUT);
      if (complete) begin
        value_q <= shadow_q;
        derr_q  <= |err_q;
      end
    end
  assign value_out   = value_q;
  assign value_valid = valid_q;
  assign digit_err   = derr_q;
  assign stale       = stale_q;
endmodule
